// File: rtl/axil_uart_rx_dma.sv
// UART receiver feeding a word FIFO that is drained by an AXI4-Lite write master.
// Define AXIL_UART_PARITY_EN to expect a parity bit between bit 7 and the stop bit.
module axil_uart_rx_dma #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int ODD_PARITY  = 0
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [15:0]             word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    Interrupt,
  output logic                    err_bresp,
  output logic                    err_frame,
  output logic                    err_overrun,
  input  logic                    UART_RX_I,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
  localparam int BPW = DATA_WIDTH / 8;
  localparam int BSH = $clog2(BPW);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW  = $clog2(CLKS_PER_BIT + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ADDR_DATA, S_RESP, S_DONE} st_t;

  rx_st_t          rx_st, rx_st_n;
  logic            rx_s1, rx_s2, rx_s3, rx_tick, par_bit, par_ok, byte_vld, frame_bad;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_sh;

  always_comb begin
    rx_tick = 1'b0;
    if (rx_st == RX_START)     rx_tick = (clk_cnt == CW'(CLKS_PER_BIT/2 - 1));
    else if (rx_st != RX_IDLE) rx_tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    rx_st_n = rx_st;
    case (rx_st)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_st_n = RX_START;
      RX_START: if (rx_tick) rx_st_n = rx_s2 ? RX_IDLE : RX_DATA;  // high at mid-start: glitch
`ifdef AXIL_UART_PARITY_EN
      RX_DATA:  if (rx_tick && bit_cnt == 3'd7) rx_st_n = RX_PAR;
`else
      RX_DATA:  if (rx_tick && bit_cnt == 3'd7) rx_st_n = RX_STOP;
`endif
      RX_PAR:   if (rx_tick) rx_st_n = RX_STOP;
      RX_STOP:  if (rx_tick) rx_st_n = RX_IDLE;
      default:  rx_st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_st     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      byte_vld  <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {UART_RX_I, rx_s1, rx_s2};
      rx_st     <= rx_st_n;
      clk_cnt   <= (rx_tick || rx_st == RX_IDLE) ? '0 : clk_cnt + 1'b1;
      byte_vld  <= 1'b0;
      frame_bad <= 1'b0;
      if (rx_st == RX_START) bit_cnt <= '0;
      if (rx_st == RX_DATA && rx_tick) begin
        rx_sh   <= {rx_s2, rx_sh[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rx_st == RX_STOP && rx_tick) begin
        byte_vld  <= rx_s2 & par_ok;
        frame_bad <= ~(rx_s2 & par_ok);
      end
    end
  end

`ifdef AXIL_UART_PARITY_EN
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET)                    par_bit <= 1'b0;
    else if (rx_st == RX_PAR && rx_tick) par_bit <= rx_s2;
  end
`else
  // No parity bit on the line: tie it to the value that always checks good.
  assign par_bit = (^rx_sh) ^ (ODD_PARITY != 0);
`endif
  assign par_ok = (((^rx_sh) ^ par_bit) == (ODD_PARITY != 0));

  st_t                  st, st_n;
  logic                 accept, pop, aw_nxt, w_nxt, full, empty, push;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]          cnt_q, idx;
  logic [BCW-1:0]       byte_cnt;
  logic [DATA_WIDTH-1:0] pack_buf, pack_word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;

  assign busy        = (st != S_IDLE);
  assign done        = (st == S_DONE);
  assign M_AXI_WSTRB = '1;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push  = byte_vld && busy && (byte_cnt == BCW'(BPW - 1));

  always_comb begin
    pack_word = pack_buf;
    pack_word[8*byte_cnt +: 8] = rx_sh;
  end

  always_comb begin
    st_n   = st;
    accept = 1'b0;
    pop    = 1'b0;
    aw_nxt = M_AXI_AWVALID & ~M_AXI_AWREADY;
    w_nxt  = M_AXI_WVALID & ~M_AXI_WREADY;
    case (st)
      S_IDLE:      if (start) begin
                     accept = 1'b1;
                     st_n   = (word_count == 16'd0) ? S_DONE : S_FETCH;
                   end
      S_FETCH:     if (!empty) begin
                     pop  = 1'b1;
                     st_n = S_ADDR_DATA;
                   end
      S_ADDR_DATA: if (!aw_nxt && !w_nxt) st_n = S_RESP;
      S_RESP:      if (M_AXI_BVALID)
                     st_n = (M_AXI_BRESP != 2'b00 || idx + 16'd1 == cnt_q) ? S_DONE : S_FETCH;
      S_DONE:      st_n = S_IDLE;
      default:     st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      st <= S_IDLE;
      base_q <= '0; cnt_q <= '0; idx <= '0;
      M_AXI_AWADDR <= '0; M_AXI_WDATA <= '0;
      M_AXI_AWVALID <= 1'b0; M_AXI_WVALID <= 1'b0; M_AXI_BREADY <= 1'b0;
      Interrupt <= 1'b0; err_bresp <= 1'b0; err_frame <= 1'b0;
    end else begin
      st <= st_n;
      if (accept) begin
        base_q <= base_addr; cnt_q <= word_count; idx <= '0;
        Interrupt <= 1'b0; err_bresp <= 1'b0; err_frame <= 1'b0;
      end
      if (pop) begin
        M_AXI_AWADDR  <= base_q + (ADDR_WIDTH'(idx) << BSH);
        M_AXI_WDATA   <= mem[rd_ptr[PW-1:0]];
        M_AXI_AWVALID <= 1'b1;
        M_AXI_WVALID  <= 1'b1;
      end
      if (st == S_ADDR_DATA) begin
        M_AXI_AWVALID <= aw_nxt;
        M_AXI_WVALID  <= w_nxt;
        if (!aw_nxt && !w_nxt) M_AXI_BREADY <= 1'b1;
      end
      if (st == S_RESP && M_AXI_BVALID) begin
        M_AXI_BREADY <= 1'b0;
        idx <= idx + 16'd1;
        if (M_AXI_BRESP != 2'b00) err_bresp <= 1'b1;
      end
      if (st == S_DONE) Interrupt <= 1'b1;
      if (frame_bad)    err_frame <= 1'b1;
    end
  end

  // Packer and FIFO pointers; a full FIFO drops the completed word.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET || accept) begin
      byte_cnt <= '0; pack_buf <= '0;
      wr_ptr <= '0; rd_ptr <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (byte_vld && busy) begin
        if (push) begin
          byte_cnt <= '0;
          pack_buf <= '0;
          if (full) err_overrun <= 1'b1;
          else      wr_ptr <= wr_ptr + 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          pack_buf <= pack_word;
        end
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK)
    if (push && !full) mem[wr_ptr[PW-1:0]] <= pack_word;

endmodule

// File: tb/tb_axil_uart_rx_dma.sv
// Bench for axil_uart_rx_dma: UART byte driver, negedge AXI slave and write scoreboard.
module tb_axil_uart_rx_dma;
  localparam int CPB = 100;

  logic        clk = 0, rst = 1, start = 0, rx = 1;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, irq, err_bresp, err_frame, err_overrun;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready;
  logic        awready = 0, wready = 0, bvalid = 0;
  logic [1:0]  bresp = 0;

  always #5 clk = ~clk;

  axil_uart_rx_dma #(.CLK_FREQ_HZ(100000000), .BAUDRATE(1000000), .ADDR_WIDTH(32),
                     .DATA_WIDTH(32), .FIFO_DEPTH(2), .ODD_PARITY(0)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .Interrupt(irq),
    .err_bresp(err_bresp), .err_frame(err_frame), .err_overrun(err_overrun),
    .UART_RX_I(rx), .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready));

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [31:0] base; logic [15:0] cnt; int nw; int awd; int wd; int err;
    int exp_wr; logic exp_berr;
  } vec_t;

  wr_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int aw_dly = 0, w_dly = 0, err_at = -1, aw_wait = 0, w_wait = 0, b_idx = 0;
  int aw_hs_cnt = 0, done_cnt = 0, done_cyc = 0, last_b_cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] cap_addr = 0, cap_data = 0, prev_addr = 0, prev_data = 0;
  bit aw_stall = 0, w_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave plus monitor: ready/valid decided at negedge, handshake lands on next posedge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; aw_wait = 0; w_wait = 0; aw_stall = 0; w_stall = 0;
    end else begin
      if (awvalid) begin
        if (aw_stall) chk("awaddr_stable", awaddr, prev_addr);
        awready = (aw_wait >= aw_dly);
        if (awready) begin cap_addr = awaddr; aw_cyc = cyc; aw_hs_cnt++; aw_wait = 0; end
        else aw_wait++;
        aw_stall = !awready; prev_addr = awaddr;
      end else begin awready = 0; aw_wait = 0; aw_stall = 0; end
      if (wvalid) begin
        if (w_stall) chk("wdata_stable", wdata, prev_data);
        wready = (w_wait >= w_dly);
        if (wready) begin cap_data = wdata; w_cyc = cyc; w_wait = 0; end
        else w_wait++;
        w_stall = !wready; prev_data = wdata;
      end else begin wready = 0; w_wait = 0; w_stall = 0; end
      if (bready) begin
        wr_t e;
        bvalid = 1;
        bresp = (b_idx == err_at) ? 2'b10 : 2'b00;
        b_idx++; last_b_cyc = cyc;
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("awaddr", cap_addr, e.addr);
          chk("wdata", cap_data, e.data);
          if (aw_dly > w_dly) chk("w_before_aw", 32'(w_cyc < aw_cyc), 1);
          else if (w_dly > aw_dly) chk("aw_before_w", 32'(aw_cyc < w_cyc), 1);
        end
      end else bvalid = 0;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    if (!stop) bit_out(1'b1);
  endtask

  task automatic do_start(input logic [31:0] ba, input logic [15:0] wc);
    base_addr = ba; word_count = wc; start = 1;
    @(posedge clk); #2;
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin @(posedge clk); #2; n++; end
    chk("done_seen", 32'(done_cnt != d0), 1);
    if (n > 0 && done_cnt != d0) begin
      chk("done_one_cycle", done, 0);
      chk("irq_after_done", irq, 1);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    vec_t vt[5];
    logic [7:0]  bq[$];
    logic [7:0]  b;
    logic [31:0] word;
    int a0, d0;

    vt[0] = '{32'h0000_1000, 16'd2, 2, 0, 0, -1, 2, 1'b0};
    vt[1] = '{32'h0000_2000, 16'd2, 2, 5, 0, -1, 2, 1'b0};
    vt[2] = '{32'h0000_3000, 16'd2, 2, 0, 5, -1, 2, 1'b0};
    vt[3] = '{32'h0000_4000, 16'd3, 2, 0, 0,  0, 1, 1'b1};
    vt[4] = '{32'hFFFF_FFFC, 16'd2, 2, 0, 0, -1, 2, 1'b0};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);     chk("rst_irq", irq, 0);
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0); chk("rst_bready", bready, 0);
    chk("rst_wstrb", wstrb, 4'hF);  chk("rst_awaddr", awaddr, 0); chk("rst_wdata", wdata, 0);
    chk("rst_errs", {err_bresp, err_frame, err_overrun}, 0);
    rst = 0;
    repeat (4) @(posedge clk);
    #2;

    for (int v = 0; v < 5; v++) begin
      aw_dly = vt[v].awd; w_dly = vt[v].wd; err_at = vt[v].err; b_idx = 0;
      a0 = aw_hs_cnt; d0 = done_cnt;
      bq.delete();
      do_start(vt[v].base, vt[v].cnt);
      for (int w = 0; w < vt[v].nw; w++) begin
        word = '0;
        for (int k = 0; k < 4; k++) begin
          b = (v == 0) ? 8'(17 * (w*4 + k + 1)) : 8'($urandom);
          bq.push_back(b);
          word = word | (32'(b) << (8*k));
        end
        if (w < vt[v].exp_wr) exp_q.push_back('{vt[v].base + 32'(w*4), word});
      end
      foreach (bq[i]) send_byte(bq[i], 1'b1);
      wait_done(d0);
      repeat (3) @(posedge clk);
      #2;
      chk("done_count", 32'(done_cnt - d0), 1);
      chk("aw_count", 32'(aw_hs_cnt - a0), 32'(vt[v].exp_wr));
      chk("done_after_last_b", 32'(done_cyc), 32'(last_b_cyc + 1));
      chk("irq_level", irq, 1);
      chk("busy_end", busy, 0);
      chk("err_bresp", err_bresp, vt[v].exp_berr);
      chk("err_frame", err_frame, 0);
      chk("err_overrun", err_overrun, 0);
      chk("sb_empty", 32'(exp_q.size()), 0);
    end

    // Backpressure: AW stalled while 4 words arrive into a 2-deep FIFO.
    aw_dly = 1000000; w_dly = 0; err_at = -1; b_idx = 0;
    a0 = aw_hs_cnt; d0 = done_cnt;
    bq.delete();
    do_start(32'h0000_5000, 16'd3);
    chk("irq_cleared_by_start", irq, 0);
    for (int w = 0; w < 4; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom); bq.push_back(b);
        word = word | (32'(b) << (8*k));
      end
      if (w < 3) exp_q.push_back('{32'h0000_5000 + 32'(w*4), word});
    end
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    chk("overrun_set", err_overrun, 1);
    chk("aw_stalled", awvalid, 1);
    chk("aw_stalled_addr", awaddr, 32'h0000_5000);
    aw_dly = 0;
    wait_done(d0);
    repeat (2) @(posedge clk);
    #2;
    chk("ovr_aw_count", 32'(aw_hs_cnt - a0), 3);
    chk("ovr_sb_empty", 32'(exp_q.size()), 0);
    chk("overrun_sticky", err_overrun, 1);

    // Frame error then reset while the write sits in the address/data phase.
    aw_dly = 1000000; d0 = done_cnt;
    do_start(32'h0000_6000, 16'd1);
    send_byte(8'hA5, 1'b0);
    chk("frame_err", err_frame, 1);
    word = '0;
    for (int k = 0; k < 4; k++) begin
      b = 8'(8'h30 + k);
      send_byte(b, 1'b1);
      word = word | (32'(b) << (8*k));
    end
    repeat (10) @(posedge clk);
    #2;
    chk("frame_word_data", cap_data, word);
    chk("frame_awvalid", awvalid, 1);
    chk("frame_awaddr", awaddr, 32'h0000_6000);
    rst = 1;
    @(posedge clk); #2;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_frame", err_frame, 0);
    rst = 0; aw_dly = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);

    // Zero length: done on the cycle after start, no AXI traffic.
    a0 = aw_hs_cnt; d0 = done_cnt;
    do_start(32'h0000_7000, 16'd0);
    chk("zero_done", done, 1);
    @(posedge clk); #2;
    chk("zero_done_pulse", done, 0);
    chk("zero_irq", irq, 1);
    chk("zero_busy", busy, 0);
    repeat (10) @(posedge clk);
    #2;
    chk("zero_done_count", 32'(done_cnt - d0), 1);
    chk("zero_no_aw", 32'(aw_hs_cnt - a0), 0);
    chk("zero_no_awvalid", awvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/axil_uart_rx_dma.md
# axil_uart_rx_dma

Parametrised UART-to-memory write engine. It receives a serial byte stream on `UART_RX_I`, packs bytes little-endian into `DATA_WIDTH` words, and buffers the words in an internal FIFO. It then writes them over an AXI4-Lite master write port to consecutive addresses from `base_addr`. It replaces the single-word UART/SRAM bridge and adds FIFO backpressure, independent AW/W handshakes, write-response checking, programmable transfer length and a completion interrupt.

## Interface
- `CLK_FREQ_HZ`, 100000000, `M_AXI_ACLK` frequency.
- `BAUDRATE`, 9600, UART bit rate. `CLKS_PER_BIT = CLK_FREQ_HZ/BAUDRATE`, integer divide, must be ≥ 4.
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, AXI data width; one of 8/16/32/64. `BPW = DATA_WIDTH/8`.
- `FIFO_DEPTH`, 8, word FIFO depth; power of 2, ≥ 2.
- `ODD_PARITY`, 0, parity sense when parity is compiled in.
- `M_AXI_ACLK` in 1: the single clock.
- `M_AXI_ARESET` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a transfer; ignored while `busy`.
- `base_addr` in `ADDR_WIDTH`: first word address, sampled on `start`; must be `BPW`-aligned.
- `word_count` in 16: number of words to write, sampled on `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `Interrupt` out 1: level; set with `done`, cleared by next accepted `start`.
- `err_bresp` out 1: sticky; a non-OKAY BRESP aborted the transfer.
- `err_frame` out 1: sticky; a byte failed stop-bit or parity check.
- `err_overrun` out 1: sticky; a word was dropped because the FIFO was full.
- `UART_RX_I` in 1: asynchronous serial input; idle high.
- `M_AXI_AWADDR` out `ADDR_WIDTH`; `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out `DATA_WIDTH`; `M_AXI_WSTRB` out `DATA_WIDTH/8`; `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.

## Operation
- **RX front end**
  - 2-FF synchroniser on `UART_RX_I`.
  - A falling edge while idle starts the bit counter.
  - The start bit is re-checked at `CLKS_PER_BIT/2`; if high, it is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first, one every `CLKS_PER_BIT`, at mid-bit.
  - A stop bit of 0 discards the byte and sets `err_frame`.
- **Packer**
  - Byte k of a word goes to `WDATA[8k+7:8k]`.
  - After `BPW` bytes, the word is pushed to the FIFO.
  - A push into a full FIFO drops the word and sets `err_overrun`; the packer continues.
  - The packer and FIFO clear on accepted `start`. Bytes received while not `busy` are discarded.
- **FSM states**
  - **S_IDLE**: `start` latches `base_addr` and `word_count`, clears the sticky errors and `Interrupt`, and moves to S_FETCH. If `word_count == 0`, move to S_DONE instead.
  - **S_FETCH**: on FIFO not empty, pop a word, load `AWADDR = base + idx*BPW` and `WDATA`, set `AWVALID = WVALID = 1`, and move to S_ADDR_DATA.
  - **S_ADDR_DATA**
    - `AWVALID` drops on its own AW handshake; `WVALID` drops on its own W handshake. Either handshake may come first or both may complete in the same cycle.
    - When both have completed, set `BREADY = 1` and move to S_RESP.
    - `AWADDR`/`WDATA` stay stable while their valid is high.
  - **S_RESP**: on `BVALID`, drop `BREADY` and increment idx.
    - If `BRESP != 2'b00`: set `err_bresp` and move to S_DONE.
    - Else if idx equals the count: move to S_DONE.
    - Else: move to S_FETCH.
  - **S_DONE**: pulse `done`, set `Interrupt`, and move to S_IDLE.
- **Fixed behaviour**
  - `WSTRB` is constant all-ones.
  - At most one write is outstanding.
  - The address adder is `ADDR_WIDTH` wide and wraps modulo 2^`ADDR_WIDTH`.
  - idx is 16 bits.
- **Reset mid-operation**: all state returns to reset values, valids drop immediately, and a partial word is lost.

## Timing
- **Reset values**: all outputs are 0 except `M_AXI_WSTRB` (all-ones). FSM is in S_IDLE; FIFO is empty.
- **`start` to `busy`**: `start` in cycle N gives `busy` = 1 in cycle N+1.
- **RX latency**: the stop-bit mid-sample in cycle N pushes the word (if it is the last byte) in cycle N+1. A non-empty FIFO in S_FETCH gives valids high the next cycle.
- **Throughput**: with always-ready slave and immediate `BVALID`, 1 word per 3 cycles.
- **Last B handshake**: the final B handshake in cycle N gives `done` in N+1, `busy` = 0 and `Interrupt` = 1 in N+2.

## Configuration
- **`AXIL_UART_PARITY_EN` defined**: a parity bit follows the data bits.
  - Even parity if `ODD_PARITY == 0`, odd otherwise.
  - A mismatch discards the byte and sets `err_frame`.
- **Undefined**: no parity bit; the stop bit follows bit 7.

## Test plan
- **Basic transfer**: 100 MHz, 1 Mbaud, `DATA_WIDTH` 32, `base_addr` 0x1000, `word_count` 2, send bytes 0x11..0x88.
  - Writes 0x44332211 @0x1000 and 0x88776655 @0x1004.
  - `done` pulses once; `Interrupt` = 1; no errors.
- **Split AW/W handshakes**: `AWREADY` delayed 5 cycles, `WREADY` immediate, then the reverse.
  - `WVALID` drops first, then `AWVALID`, then the roles swap.
  - Exactly one B wait per word; data is unchanged.
- **Backpressure/overrun**: `FIFO_DEPTH` 2, `AWREADY` held 0 while 4 words arrive.
  - Words 1–2 are buffered and word 3 is dropped.
  - `err_overrun` = 1.
- **Slave error**: `BRESP` = 2'b10 on word 1 of 3.
  - `err_bresp` = 1 and `done` pulses after word 1.
  - No second AWVALID is issued.
- **Frame error and reset**: byte 0xA5 with stop bit 0 sets `err_frame` and the word is not written. Then assert `M_AXI_ARESET` during S_ADDR_DATA: next cycle all valids are 0 and `busy` is 0.
- **Zero length**: `start` with `word_count` 0.
  - `done` pulses at cycle N+1; no AXI activity.
